// File: rtl/store_trace_buffer.sv
// Store trace buffer: captures processor data-memory stores into a small
// circular record FIFO and streams each record out as a 10-byte packet
// (0xA5 header, address byte, 8 data bytes little-endian) over a
// valid/ready byte interface.
module store_trace_buffer #(
  parameter int N     = 64,
  parameter int DEPTH = 8
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [N-1:0] wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic         drain_en,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         full,
  output logic         empty,
  output logic [7:0]   drop_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = N + 6;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    ADDR,
    DATA
  } state_t;

  // Record storage and FIFO bookkeeping
  logic [RW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // Serializer state
  state_t        state;
  logic [2:0]    byte_idx;
  logic [2:0]    next_idx;

  // Head-of-FIFO record fields
  logic [RW-1:0] head_rec;
  logic [5:0]    head_addr;
  logic [63:0]   head_data;

  logic          pop;
  logic          push_ok;
  logic          unused_addr_bits;

  // Only address bits [8:3] are part of a record.
  assign unused_addr_bits = ^{wr_addr[N-1:9], wr_addr[2:0]};

  assign head_rec  = mem[rd_ptr];
  assign head_addr = head_rec[RW-1:N];

  if (N >= 64) begin : g_data_wide
    assign head_data = head_rec[63:0];
  end else begin : g_data_narrow
    assign head_data = {{(64 - N){1'b0}}, head_rec[N-1:0]};
  end

  // The record leaves the FIFO only when its last data byte is accepted.
  assign pop      = (state == DATA) && (byte_idx == 3'd7) && out_ready;
  // A pop on the same edge frees the slot the push needs.
  assign push_ok  = wr_en && (!full || pop);
  assign next_idx = byte_idx + 3'd1;

  // Next occupancy; push and pop together leave it unchanged
  always_comb begin
    count_next = count;
    if (push_ok && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push_ok) begin
      count_next = count - 1'b1;
    end
  end

  // Record write port; reset discards contents through the pointers
  always_ff @(posedge CLOCK_50) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= {wr_addr[8:3], wr_data};
    end
  end

  // FIFO pointers, occupancy flags and saturating drop counter
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      drop_count <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == FULL_COUNT);
      empty <= (count_next == '0);
      if (wr_en && !push_ok && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  // Byte serializer FSM with registered out_data/out_valid
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      byte_idx  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (drain_en && !empty) begin
            state     <= HDR;
            out_valid <= 1'b1;
            out_data  <= 8'hA5;
          end
        end
        HDR: begin
          if (out_ready) begin
            state    <= ADDR;
            out_data <= {2'b00, head_addr};
          end
        end
        ADDR: begin
          if (out_ready) begin
            state    <= DATA;
            byte_idx <= '0;
            out_data <= head_data[7:0];
          end
        end
        DATA: begin
          if (out_ready) begin
            if (byte_idx == 3'd7) begin
              state     <= IDLE;
              byte_idx  <= '0;
              out_valid <= 1'b0;
            end else begin
              byte_idx <= next_idx;
              out_data <= head_data[{next_idx, 3'b000} +: 8];
            end
          end
        end
        default: begin
          state     <= IDLE;
          byte_idx  <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_trace_buffer.sv
// Self-checking bench for store_trace_buffer: a per-cycle vector table for
// the single-record stream, then directed sequences for overflow, stalls,
// full-with-pop, mid-record reset and drop counter saturation.
module tb_store_trace_buffer;

  localparam int N     = 64;
  localparam int DEPTH = 8;

  logic         CLOCK_50 = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [N-1:0] wr_addr;
  logic [N-1:0] wr_data;
  logic         drain_en;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         full;
  logic         empty;
  logic [7:0]   drop_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx [100];
  int         rx_n;

  typedef struct {
    logic        wr_en;
    logic [63:0] addr;
    logic [63:0] data;
    logic        drain_en;
    logic        out_ready;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_full;
    logic        exp_empty;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t vt [12];

  store_trace_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .drain_en   (drain_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .full       (full),
    .empty      (empty),
    .drop_count (drop_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_data(input int i);
    return 64'h1122334455667700 + 64'(i) * 64'h0101010101010101;
  endfunction

  function automatic logic [63:0] mk_addr(input int i);
    return 64'hFFFF000000000005 | (64'(i) << 3);
  endfunction

  function automatic logic [7:0] exp_byte(input int i, input int k);
    logic [63:0] d;
    d = mk_data(i);
    if (k == 0) return 8'hA5;
    if (k == 1) return {2'b00, 6'(i)};
    return d[(k - 2) * 8 +: 8];
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    drain_en  = 1'b0;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_stores(input int first, input int n);
    for (int j = 0; j < n; j++) begin
      wr_en   = 1'b1;
      wr_addr = mk_addr(first + j);
      wr_data = mk_data(first + j);
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Collect n accepted bytes into rx; with stall set, out_ready is
  // randomised and every stalled cycle is checked for a held output.
  task automatic recv_bytes(input string name, input int n, input bit stall);
    logic [7:0] held;
    rx_n = 0;
    for (int c = 0; c < 3000 && rx_n < n; c++) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && !out_ready) begin
        held = out_data;
        tick();
        chk({name, "_stall_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_stall_data"}, 64'(out_data), 64'(held));
      end else begin
        if (out_valid) begin
          rx[rx_n] = out_data;
          rx_n++;
        end
        tick();
      end
    end
    out_ready = 1'b1;
    chk({name, "_byte_count"}, 64'(rx_n), 64'(n));
  endtask

  task automatic check_rec(input string name, input int base, input int i);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s_b%0d", name, k), 64'(rx[base + k]), 64'(exp_byte(i, k)));
    end
  endtask

  initial begin
    // Single store A=0x48, D=0x0123456789ABCDEF streamed with no stalls.
    vt[0]  = '{1'b1, 64'h48, 64'h0123456789ABCDEF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    vt[1]  = '{1'b0, 64'h0,  64'h0,                1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'd0};
    vt[2]  = '{1'b0, 64'h0,  64'h0,                1'b1, 1'b1, 1'b1, 8'h09, 1'b0, 1'b0, 8'd0};
    vt[3]  = '{1'b0, 64'h0,  64'h0,                1'b1, 1'b1, 1'b1, 8'hEF, 1'b0, 1'b0, 8'd0};
    vt[4]  = '{1'b0, 64'h0,  64'h0,                1'b1, 1'b1, 1'b1, 8'hCD, 1'b0, 1'b0, 8'd0};
    vt[5]  = '{1'b0, 64'h0,  64'h0,                1'b1, 1'b1, 1'b1, 8'hAB, 1'b0, 1'b0, 8'd0};
    vt[6]  = '{1'b0, 64'h0,  64'h0,                1'b1, 1'b1, 1'b1, 8'h89, 1'b0, 1'b0, 8'd0};
    vt[7]  = '{1'b0, 64'h0,  64'h0,                1'b1, 1'b1, 1'b1, 8'h67, 1'b0, 1'b0, 8'd0};
    vt[8]  = '{1'b0, 64'h0,  64'h0,                1'b1, 1'b1, 1'b1, 8'h45, 1'b0, 1'b0, 8'd0};
    vt[9]  = '{1'b0, 64'h0,  64'h0,                1'b1, 1'b1, 1'b1, 8'h23, 1'b0, 1'b0, 8'd0};
    vt[10] = '{1'b0, 64'h0,  64'h0,                1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 8'd0};
    vt[11] = '{1'b0, 64'h0,  64'h0,                1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0};

    // Reset state, sampled after an edge with reset high
    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    drain_en  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data),  64'h00);
    chk("rst_full",  64'(full),      64'd0);
    chk("rst_empty", 64'(empty),     64'd1);
    chk("rst_drop",  64'(drop_count), 64'd0);
    reset = 1'b0;

    // Table-driven single record; row 0 is the first edge after reset
    for (int i = 0; i < 12; i++) begin
      wr_en     = vt[i].wr_en;
      wr_addr   = vt[i].addr;
      wr_data   = vt[i].data;
      drain_en  = vt[i].drain_en;
      out_ready = vt[i].out_ready;
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vt[i].exp_valid));
      if (vt[i].exp_valid) begin
        chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(vt[i].exp_data));
      end
      chk($sformatf("vec%0d_full", i),  64'(full),       64'(vt[i].exp_full));
      chk($sformatf("vec%0d_empty", i), 64'(empty),      64'(vt[i].exp_empty));
      chk($sformatf("vec%0d_drop", i),  64'(drop_count), 64'(vt[i].exp_drop));
    end
    wr_en = 1'b0;

    // Overflow with draining disabled, then in-order emission
    do_reset();
    do_stores(0, DEPTH + 3);
    chk("ovf_full",  64'(full),       64'd1);
    chk("ovf_empty", 64'(empty),      64'd0);
    chk("ovf_drop",  64'(drop_count), 64'd3);
    chk("ovf_idle",  64'(out_valid),  64'd0);
    drain_en = 1'b1;
    recv_bytes("ovf", DEPTH * 10, 1'b0);
    for (int r = 0; r < DEPTH; r++) begin
      check_rec($sformatf("ovf_rec%0d", r), r * 10, r);
    end
    chk("ovf_empty_after", 64'(empty), 64'd1);

    // Randomly stalled sink yields the same byte sequence
    do_reset();
    drain_en = 1'b1;
    do_stores(21, 1);
    recv_bytes("stall", 10, 1'b1);
    check_rec("stall_rec", 0, 21);
    chk("stall_empty_after", 64'(empty), 64'd1);

    // Full FIFO with a push on the edge that pops the head record
    do_reset();
    do_stores(0, DEPTH);
    chk("fp_full_before", 64'(full), 64'd1);
    drain_en = 1'b1;
    recv_bytes("fp_head", 9, 1'b0);
    chk("fp_last_valid", 64'(out_valid), 64'd1);
    rx[9]   = out_data;
    wr_en   = 1'b1;
    wr_addr = mk_addr(20);
    wr_data = mk_data(20);
    tick();
    wr_en = 1'b0;
    check_rec("fp_rec0", 0, 0);
    chk("fp_full_after",  64'(full),       64'd1);
    chk("fp_drop_after",  64'(drop_count), 64'd0);
    chk("fp_idle_gap",    64'(out_valid),  64'd0);
    tick();
    chk("fp_b2b_valid",   64'(out_valid),  64'd1);
    chk("fp_b2b_hdr",     64'(out_data),   64'hA5);
    recv_bytes("fp_rest", DEPTH * 10, 1'b0);
    for (int r = 0; r < DEPTH - 1; r++) begin
      check_rec($sformatf("fp_rec%0d", r + 1), r * 10, r + 1);
    end
    check_rec("fp_rec_new", (DEPTH - 1) * 10, 20);
    chk("fp_empty_after", 64'(empty), 64'd1);

    // Reset at DATA byte index 3 with a simultaneous store
    do_reset();
    do_stores(0, DEPTH + 2);
    chk("mr_drop_before", 64'(drop_count), 64'd2);
    drain_en = 1'b1;
    recv_bytes("mr_part", 5, 1'b0);
    chk("mr_at_idx3_valid", 64'(out_valid), 64'd1);
    chk("mr_at_idx3_data",  64'(out_data),  64'(exp_byte(0, 5)));
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = mk_addr(9);
    wr_data = mk_data(9);
    tick();
    reset = 1'b0;
    wr_en = 1'b0;
    chk("mr_valid", 64'(out_valid),  64'd0);
    chk("mr_empty", 64'(empty),      64'd1);
    chk("mr_full",  64'(full),       64'd0);
    chk("mr_drop",  64'(drop_count), 64'd0);
    do_stores(33, 1);
    chk("mr_first_store", 64'(empty), 64'd0);
    recv_bytes("mr_fresh", 10, 1'b0);
    check_rec("mr_fresh_rec", 0, 33);
    chk("mr_empty_after", 64'(empty), 64'd1);

    // Drop counter saturates at 255
    do_reset();
    do_stores(0, DEPTH);
    do_stores(100, 300);
    chk("sat_drop", 64'(drop_count), 64'd255);
    chk("sat_full", 64'(full),       64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
